dseg_source_arbiter: RTL and testbench
======================================

# dseg_source_arbiter

Display-source arbiter for the 4-digit segment display path. Shares the single 16-bit `display_num` input of the segment driver among three requesters (free-running counter, user value, urgent/alarm value) with round-robin selection, a minimum dwell time per source and optional urgent preemption. Sits between the value producers and the segment driver in the 25 MHz domain, downstream of the PLL lock-derived reset.

## Interface
- `HOLD_CYCLES`, default 25_000_000: minimum dwell per grant, in clk cycles (1 s at 25 MHz); legal range >= 2.
- `IDLE_NUM`, default 16'h0000: value driven on `display_num` when nothing is granted.
- `URGENT_EN`, default 1: 1 lets requester 2 preempt mid-dwell; 0 means plain round-robin.

- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `req`  in  3: level requests, bit i = requester i.
- `num0`, `num1`, `num2`  in  16 each: display words of requesters 0..2.
- `grant`  out  3: one-hot current owner, 000 when idle.
- `display_num`  out  16: value to segment driver.
- `dseg_blank`  out  1: 1 = nothing granted; driver blanks digits.
- `dseg_update`  out  1: one-cycle pulse when owner changes (incl. IDLE->owner).

## Operation
- States: IDLE, HOLD. Internal: `ptr` (2 bits, last granted index), `dwell` counter of width clog2(HOLD_CYCLES).
- Reset values: state IDLE, `grant`=000, `display_num`=IDLE_NUM, `dseg_blank`=1, `dseg_update`=0, `ptr`=2, `dwell`=0.
- Round-robin search order from `ptr`: ptr+1, ptr+2, ptr (mod 3). From reset, search starts at index 0.
- IDLE: if any `req` bit set, grant first requester in search order, go HOLD, `dwell`=0, `ptr`=winner, `dseg_update`=1, `dseg_blank`=0. Else stay.
- HOLD: `dwell` increments each cycle. Grant kept until `dwell`==HOLD_CYCLES-1 regardless of owner's `req` (minimum dwell).
- Dwell expiry: if another requester pending -> switch to next in search order, `dwell`=0, pulse `dseg_update`. Else if owner's `req` still high -> keep owner, `dwell`=0, no pulse. Else -> IDLE, `grant`=000, `dseg_blank`=1, `display_num`=IDLE_NUM.
- Urgent (URGENT_EN=1): in HOLD with owner != 2 and `req[2]`=1, next edge grants 2, `dwell`=0, `ptr`=2, pulse. Overrides dwell expiry on the same cycle. Owner 2 is never preempted; after its dwell it competes in round-robin.
- URGENT_EN=0: requester 2 treated as ordinary requester.
- `display_num` in HOLD tracks the granted source's `num` live (registered).

## Timing
- `req` sampled on rising edge; `grant`, `dseg_blank`, `dseg_update`, `display_num` all registered and change on the same edge.
- Request-to-grant latency from IDLE: 1 cycle.
- `num` change to `display_num`: 1 cycle while granted.
- Each grant lasts exactly HOLD_CYCLES cycles before re-arbitration, except urgent preemption (switch on next edge).
- `dseg_update` high for exactly 1 cycle per owner change; never high on self-renewal or on HOLD->IDLE.
- Asynchronous reset mid-HOLD: all outputs take reset values immediately, no clock needed; first grant after release follows reset search order.

## Test plan
- Reset, `req`=000 for 20 cycles -> `grant`=000, `dseg_blank`=1, `display_num`=16'h0000, `dseg_update` never high.
- HOLD_CYCLES=4, `req`=001, `num0`=16'h1234 -> one edge later `grant`=001, `display_num`=16'h1234, one `dseg_update` pulse; grant renews every 4 cycles with no further pulse; changing `num0` to 16'h5678 appears 1 cycle later.
- HOLD_CYCLES=4, `req`=011 held from IDLE -> `grant` 001 for 4 cycles, 010 for 4, 001 for 4..., pulse at each switch.
- `grant`=001, drop `req[0]` after 1 cycle -> `grant` stays 001 until 4 cycles total, then 000, `dseg_blank`=1, `display_num`=IDLE_NUM.
- URGENT_EN=1, `grant`=001 at dwell 1, raise `req[2]` with `num2`=16'hDEAD -> next edge `grant`=100, `display_num`=16'hDEAD, pulse; with URGENT_EN=0 switch waits for dwell expiry.
- Assert `rst_n`=0 between edges mid-HOLD -> outputs reset immediately; after release with `req`=111, first grant is 001.

Source files
------------

// File: rtl/dseg_source_arbiter.sv
// dseg_source_arbiter: shares the segment driver's 16-bit display word among
// three requesters using round-robin with a minimum dwell per grant and
// optional urgent preemption by requester 2.
//
// Ports:
//   clk, rst_n   - 25 MHz clock, asynchronous active-low reset
//   req[2:0]     - level requests, bit i = requester i
//   num0..num2   - display words of requesters 0..2
//   grant[2:0]   - one-hot current owner, 000 when idle
//   display_num  - registered word for the segment driver
//   dseg_blank   - 1 when nothing is granted
//   dseg_update  - one-cycle pulse on every owner change
module dseg_source_arbiter #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter logic [15:0] IDLE_NUM    = 16'h0000,
  parameter bit          URGENT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] num0,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [2:0]  grant,
  output logic [15:0] display_num,
  output logic        dseg_blank,
  output logic        dseg_update
);

  localparam int unsigned NUM_W   = 16;
  localparam int unsigned DWELL_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [DWELL_W-1:0] dwell;

  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] rr_idx;
  logic       rr_valid;
  logic       urgent;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : 2'(x + 2'd1);
  endfunction

  function automatic logic [NUM_W-1:0] pick_num(input logic [1:0]       idx,
                                                input logic [NUM_W-1:0] a,
                                                input logic [NUM_W-1:0] b,
                                                input logic [NUM_W-1:0] c);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  // Round-robin pick: ptr+1, ptr+2, then ptr itself. In HOLD ptr is the
  // owner, so a pick equal to ptr means only the owner is still asking.
  always_comb begin
    cand1    = inc3(ptr);
    cand2    = inc3(cand1);
    rr_idx   = ptr;
    rr_valid = 1'b0;
    if (req[cand1]) begin
      rr_idx   = cand1;
      rr_valid = 1'b1;
    end else if (req[cand2]) begin
      rr_idx   = cand2;
      rr_valid = 1'b1;
    end else if (req[ptr]) begin
      rr_idx   = ptr;
      rr_valid = 1'b1;
    end
  end

  // Requester 2 may cut into another owner's dwell; never preempts itself.
  always_comb begin
    urgent = URGENT_EN && (ptr != 2'd2) && req[2];
  end

  // Arbiter state, dwell timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd2;
      dwell       <= '0;
      grant       <= 3'b000;
      display_num <= IDLE_NUM;
      dseg_blank  <= 1'b1;
      dseg_update <= 1'b0;
    end else begin
      dseg_update <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_valid) begin
            state       <= HOLD;
            ptr         <= rr_idx;
            dwell       <= '0;
            grant       <= 3'b001 << rr_idx;
            display_num <= pick_num(rr_idx, num0, num1, num2);
            dseg_blank  <= 1'b0;
            dseg_update <= 1'b1;
          end
        end
        HOLD: begin
          if (urgent) begin
            ptr         <= 2'd2;
            dwell       <= '0;
            grant       <= 3'b100;
            display_num <= num2;
            dseg_update <= 1'b1;
          end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rr_valid) begin
              ptr         <= rr_idx;
              grant       <= 3'b001 << rr_idx;
              display_num <= pick_num(rr_idx, num0, num1, num2);
              dseg_update <= (rr_idx != ptr);
            end else begin
              state       <= IDLE;
              grant       <= 3'b000;
              display_num <= IDLE_NUM;
              dseg_blank  <= 1'b1;
            end
          end else begin
            dwell       <= dwell + DWELL_W'(1);
            display_num <= pick_num(ptr, num0, num1, num2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dseg_source_arbiter.sv
// Directed bench for dseg_source_arbiter: two instances with HOLD_CYCLES=4,
// one with urgent preemption enabled and one without, sharing stimulus.
module tb_dseg_source_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] num0, num1, num2;
  logic [2:0]  g0, g1;
  logic [15:0] d0, d1;
  logic        b0, b1, u0, u1;

  int n_vec = 0;
  int n_err = 0;

  dseg_source_arbiter #(.HOLD_CYCLES(4), .IDLE_NUM(16'h0000), .URGENT_EN(1'b1)) u_urg (
    .clk(clk), .rst_n(rst_n), .req(req), .num0(num0), .num1(num1), .num2(num2),
    .grant(g0), .display_num(d0), .dseg_blank(b0), .dseg_update(u0)
  );

  dseg_source_arbiter #(.HOLD_CYCLES(4), .IDLE_NUM(16'h0000), .URGENT_EN(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .num0(num0), .num1(num1), .num2(num2),
    .grant(g1), .display_num(d1), .dseg_blank(b1), .dseg_update(u1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 3'b000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 3'b000;
    num0  = 16'h1234;
    num1  = 16'hBEEF;
    num2  = 16'hDEAD;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(g0), 32'h0);
    chk("rst_blank", 32'(b0), 32'h1);
    chk("rst_num",   32'(d0), 32'h0000);
    chk("rst_upd",   32'(u0), 32'h0);
    tick();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_grant", 32'(g0), 32'h0);
      chk("idle_upd",   32'(u0), 32'h0);
      chk("idle_blank", 32'(b0), 32'h1);
      chk("idle_num",   32'(d0), 32'h0000);
    end

    // Single requester: grant, renewal without pulse, live num tracking
    req = 3'b001;
    tick();
    chk("t1_grant", 32'(g0), 32'h1);
    chk("t1_num",   32'(d0), 32'h1234);
    chk("t1_upd",   32'(u0), 32'h1);
    chk("t1_blank", 32'(b0), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_renew_grant", 32'(g0), 32'h1);
      chk("t1_renew_upd",   32'(u0), 32'h0);
    end
    num0 = 16'h5678;
    tick();
    chk("t1_num_track", 32'(d0), 32'h5678);
    req = 3'b000;
    tick();
    chk("t1_drain_a", 32'(g0), 32'h1);
    tick();
    chk("t1_drain_b", 32'(g0), 32'h1);
    tick();
    chk("t1_idle_grant", 32'(g0), 32'h0);
    chk("t1_idle_blank", 32'(b0), 32'h1);
    chk("t1_idle_num",   32'(d0), 32'h0000);
    chk("t1_idle_upd",   32'(u0), 32'h0);
    num0 = 16'h1234;

    // Two requesters alternate every 4 cycles
    do_reset();
    req = 3'b011;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t2_grant_urg", 32'(g0), (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
      chk("t2_grant_rr",  32'(g1), (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
      chk("t2_upd",       32'(u0), ((i % 4) == 0) ? 32'h1 : 32'h0);
      chk("t2_num",       32'(d0), (((i / 4) % 2) == 0) ? 32'h1234 : 32'hBEEF);
    end

    // Owner drops request after one cycle: minimum dwell still honoured
    do_reset();
    req = 3'b001;
    tick();
    chk("t3_grant0", 32'(g0), 32'h1);
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", 32'(g0), 32'h1);
    end
    tick();
    chk("t3_idle_grant", 32'(g0), 32'h0);
    chk("t3_idle_blank", 32'(b0), 32'h1);
    chk("t3_idle_num",   32'(d0), 32'h0000);
    chk("t3_idle_upd",   32'(u0), 32'h0);

    // Urgent preemption vs. plain round-robin
    do_reset();
    req = 3'b001;
    tick();
    tick();
    chk("t4_pre_grant", 32'(g0), 32'h1);
    req = 3'b101;
    tick();
    chk("t4_urg_grant", 32'(g0), 32'h4);
    chk("t4_urg_num",   32'(d0), 32'hDEAD);
    chk("t4_urg_upd",   32'(u0), 32'h1);
    chk("t4_rr_grant",  32'(g1), 32'h1);
    chk("t4_rr_num",    32'(d1), 32'h1234);
    tick();
    chk("t4_urg_keep",  32'(g0), 32'h4);
    chk("t4_urg_noupd", 32'(u0), 32'h0);
    chk("t4_rr_keep",   32'(g1), 32'h1);
    tick();
    chk("t4_rr_switch", 32'(g1), 32'h4);
    chk("t4_rr_upd",    32'(u1), 32'h1);
    chk("t4_urg_hold",  32'(g0), 32'h4);
    tick();
    tick();
    chk("t4_urg_rr",     32'(g0), 32'h1);
    chk("t4_urg_rr_upd", 32'(u0), 32'h1);
    chk("t4_rr_still",   32'(g1), 32'h4);

    // Asynchronous reset between edges mid-HOLD
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_grant", 32'(g0), 32'h0);
    chk("t5_async_blank", 32'(b0), 32'h1);
    chk("t5_async_num",   32'(d0), 32'h0000);
    chk("t5_async_upd",   32'(u0), 32'h0);
    chk("t5_async_grant_rr", 32'(g1), 32'h0);
    req = 3'b111;
    #1 rst_n = 1'b1;
    tick();
    chk("t5_first_urg", 32'(g0), 32'h1);
    chk("t5_first_rr",  32'(g1), 32'h1);
    chk("t5_first_num", 32'(d0), 32'h1234);
    chk("t5_first_upd", 32'(u0), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
